// File: rtl/prog_run_ctrl_if.sv
// Handshake bundle between the test bench and the run sequencer.
// The master side drives Start/Halt; the slave side owns the PC load, run and status.
interface prog_run_ctrl_if #(
   parameter int unsigned A  = 10,
   parameter int unsigned CW = 16
);
   logic          Start;
   logic          Halt;
   logic          PcLoad;
   logic [A-1:0]  PcLoadAddr;
   logic          Run;
   logic          Ack;
   logic [1:0]    ProgNum;
   logic [CW-1:0] CycleCount;
   logic          Timeout;

   modport master (
      output Start, Halt,
      input  PcLoad, PcLoadAddr, Run, Ack, ProgNum, CycleCount, Timeout
   );

   modport slave (
      input  Start, Halt,
      output PcLoad, PcLoadAddr, Run, Ack, ProgNum, CycleCount, Timeout
   );
endinterface

// File: rtl/prog_run_ctrl.sv
// Run sequencer: turns test-bench Start pulses into a PC load plus a bounded run
// window per program, reporting halt/watchdog completion back to the bench.
module prog_run_ctrl #(
   parameter int unsigned A       = 10,
   parameter int unsigned NPROG   = 3,
   parameter int unsigned BASE1   = 0,
   parameter int unsigned BASE2   = 100,
   parameter int unsigned BASE3   = 200,
   parameter int unsigned CW      = 16,
   parameter int unsigned TIMEOUT = 4096
) (
   input logic             Clk,
   input logic             Reset,
   prog_run_ctrl_if.slave  bus
);
   localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);
   localparam logic [1:0]    LAST_PROG = 2'(NPROG);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state;
   logic          start_r;
   logic          pc_load;
   logic [A-1:0]  pc_load_addr;
   logic          run;
   logic          ack;
   logic [1:0]    prog_num;
   logic [CW-1:0] cycle_count;
   logic          timeout;

   logic          rise_c;
   logic          fall_c;
   logic          accept_c;
   logic [A-1:0]  base_sel_c;
   logic [CW-1:0] count_inc_c;

   assign rise_c      = ~start_r &  bus.Start;
   assign fall_c      =  start_r & ~bus.Start;
   assign count_inc_c = cycle_count + CW'(1);

   // A rise is honoured only from IDLE, or from DONE while programs remain.
   assign accept_c = rise_c &&
                     ((state == IDLE) || ((state == DONE) && (prog_num < LAST_PROG)));

   // prog_num has already advanced when the fall arrives, so it indexes the new program.
   always_comb begin
      base_sel_c = A'(BASE3);
      case (prog_num)
         2'd1:    base_sel_c = A'(BASE1);
         2'd2:    base_sel_c = A'(BASE2);
         default: base_sel_c = A'(BASE3);
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state        <= IDLE;
         start_r      <= 1'b0;
         pc_load      <= 1'b0;
         pc_load_addr <= '0;
         run          <= 1'b0;
         ack          <= 1'b0;
         prog_num     <= '0;
         cycle_count  <= '0;
         timeout      <= 1'b0;
      end else begin
         start_r <= bus.Start;
         pc_load <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept_c) begin
                  state       <= ARMED;
                  prog_num    <= prog_num + 2'd1;
                  cycle_count <= '0;
                  timeout     <= 1'b0;
                  ack         <= 1'b0;
               end
            end
            ARMED: begin
               if (fall_c) begin
                  state        <= LOAD;
                  pc_load      <= 1'b1;
                  pc_load_addr <= base_sel_c;
               end
            end
            LOAD: begin
               state <= RUN;
               run   <= 1'b1;
            end
            RUN: begin
               // Halt beats the watchdog when both land on the same edge.
               cycle_count <= count_inc_c;
               if (bus.Halt) begin
                  state   <= DONE;
                  run     <= 1'b0;
                  ack     <= 1'b1;
                  timeout <= 1'b0;
               end else if (count_inc_c == TMO_LIMIT) begin
                  state   <= DONE;
                  run     <= 1'b0;
                  ack     <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               run     <= 1'b0;
               pc_load <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PcLoad     = pc_load;
   assign bus.PcLoadAddr = pc_load_addr;
   assign bus.Run        = run;
   assign bus.Ack        = ack;
   assign bus.ProgNum    = prog_num;
   assign bus.CycleCount = cycle_count;
   assign bus.Timeout    = timeout;
endmodule
